// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types and constants for the RV32I core: datapath
//               width, canonical NOP, base opcodes, fetch FSM state and the
//               IF/ID pipeline-register payload.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

  localparam int XLEN = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  // Base RV32I major opcodes (inst[6:0])
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    FAULT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic            valid;
    logic [31:0]     inst;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } ifid_t;

endpackage : core_pkg
`default_nettype wire

// File: rtl/ifid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_reg
// Description : IF/ID pipeline register. Reset and clear both produce a
//               bubble; clear keeps the pc fields so they stay meaningful for
//               debug. Priority: rst > i_clear > i_hold > load.
// Ports       : clk     - rising-edge clock
//               rst     - synchronous active-high reset (all-zero bubble)
//               i_hold  - keep current contents
//               i_clear - replace with a bubble (valid=0, inst=NOP)
//               i_d     - next payload, loaded when neither hold nor clear
//               o_q     - registered payload
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg
  import core_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  i_hold,
  input  logic  i_clear,
  input  ifid_t i_d,
  output ifid_t o_q
);

  ifid_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q.valid    <= 1'b0;
      r_q.inst     <= NOP_INST;
      r_q.pc       <= '0;
      r_q.pc_plus4 <= '0;
    end else if (i_clear) begin
      r_q.valid <= 1'b0;
      r_q.inst  <= NOP_INST;
    end else if (!i_hold) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule : ifid_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : fetch_stage
// Description : RV32I instruction-fetch stage. Owns the PC, drives the
//               combinational instruction memory and captures the returned
//               word into IF/ID. Handles stall, flush, redirect and faults on
//               misaligned or out-of-range fetch addresses (sticky until a
//               legal redirect).
// Ports       : clock, reset        - clock, synchronous active-high reset
//               imem_pc / imem_inst - instruction memory address / word
//               stall, flush        - hazard-unit controls
//               redirect_valid/_pc  - taken branch/jump from EX
//               ifid_*              - IF/ID register contents
//               fault, fault_pc     - sticky fetch fault and offending address
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_stage #(
  // Must match core_pkg::XLEN, which sizes the IF/ID payload struct.
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int              IMEM_BYTES = 256
) (
  input  logic            clock,
  input  logic            reset,
  output logic [XLEN-1:0] imem_pc,
  input  logic [31:0]     imem_inst,
  input  logic            stall,
  input  logic            flush,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ifid_valid,
  output logic [31:0]     ifid_inst,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  import core_pkg::*;

  localparam logic [XLEN-1:0] c_last_addr = XLEN'(IMEM_BYTES - 4);

  function automatic logic f_legal(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00) && (addr <= c_last_addr);
  endfunction

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_fault;
  logic [XLEN-1:0] r_fault_pc;

  fetch_state_t    w_state_nxt;
  logic [XLEN-1:0] w_pc_nxt;
  logic            w_fault_nxt;
  logic [XLEN-1:0] w_fault_pc_nxt;
  logic            w_ifid_hold;
  logic            w_ifid_clear;
  logic [XLEN-1:0] w_pc_plus4;
  ifid_t           w_ifid_d;
  ifid_t           w_ifid_q;

  assign w_pc_plus4 = r_pc + XLEN'(4);
  assign w_ifid_d   = '{valid: 1'b1, inst: imem_inst, pc: r_pc, pc_plus4: w_pc_plus4};

  // State and PC registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= RUN;
      r_pc       <= RESET_PC;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_fault    <= w_fault_nxt;
      r_fault_pc <= w_fault_pc_nxt;
    end
  end

  // Next-state and IF/ID control. IF/ID loads only on the RUN advance path,
  // so imem_inst is never sampled on any other cycle.
  always_comb begin
    w_state_nxt    = r_state;
    w_pc_nxt       = r_pc;
    w_fault_nxt    = r_fault;
    w_fault_pc_nxt = r_fault_pc;
    w_ifid_hold    = 1'b1;
    w_ifid_clear   = 1'b0;

    case (r_state)
      RUN: begin
        if (redirect_valid) begin
          // The word fetched this cycle is wrong-path.
          w_ifid_clear = 1'b1;
          if (f_legal(redirect_pc)) begin
            w_pc_nxt = redirect_pc;
          end else begin
            w_state_nxt    = FAULT;
            w_fault_nxt    = 1'b1;
            w_fault_pc_nxt = redirect_pc;
          end
        end else if (flush) begin
          w_ifid_clear = 1'b1;
        end else if (!stall) begin
          w_ifid_hold = 1'b0;
          w_pc_nxt    = w_pc_plus4;
          // Current word is good; it is the next address that is illegal.
          if (!f_legal(w_pc_plus4)) begin
            w_state_nxt    = FAULT;
            w_fault_nxt    = 1'b1;
            w_fault_pc_nxt = w_pc_plus4;
          end
        end
      end

      FAULT: begin
        if (redirect_valid && f_legal(redirect_pc)) begin
          w_state_nxt  = RUN;
          w_fault_nxt  = 1'b0;
          w_pc_nxt     = redirect_pc;
          w_ifid_clear = 1'b1;
        end else begin
          if (redirect_valid) begin
            w_fault_pc_nxt = redirect_pc;
          end
          w_ifid_clear = !stall;
        end
      end

      default: begin
        w_state_nxt = RUN;
      end
    endcase
  end

  ifid_reg u_ifid_reg (
    .clk     (clock),
    .rst     (reset),
    .i_hold  (w_ifid_hold),
    .i_clear (w_ifid_clear),
    .i_d     (w_ifid_d),
    .o_q     (w_ifid_q)
  );

  assign imem_pc       = r_pc;
  assign ifid_valid    = w_ifid_q.valid;
  assign ifid_inst     = w_ifid_q.inst;
  assign ifid_pc       = w_ifid_q.pc;
  assign ifid_pc_plus4 = w_ifid_q.pc_plus4;
  assign fault         = r_fault;
  assign fault_pc      = r_fault_pc;

endmodule : fetch_stage
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A behavioural model of
//               the stage is stepped every rising edge and compared against
//               every output on every falling edge; directed scenarios add
//               hand-computed literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] OOR  = 32'hDEAD_BEEF;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] imem_pc;
  logic [31:0] imem_inst;
  logic        stall;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifid_valid;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        fault;
  logic [31:0] fault_pc;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  // Byte-addressed memory, big-endian words.
  logic [7:0] mem [0:255];

  function automatic logic [31:0] fetch(input logic [31:0] a);
    if (a <= 32'd252)
      return {mem[a[7:0]], mem[a[7:0] + 8'd1], mem[a[7:0] + 8'd2], mem[a[7:0] + 8'd3]};
    return OOR;
  endfunction

  function automatic logic legal(input logic [31:0] a);
    return (a[1:0] == 2'b00) && (a <= 32'd252);
  endfunction

  assign imem_inst = fetch(imem_pc);

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0), .IMEM_BYTES(256)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_pc        (imem_pc),
    .imem_inst      (imem_inst),
    .stall          (stall),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifid_valid     (ifid_valid),
    .ifid_inst      (ifid_inst),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        faulted;
    logic [31:0] pc;
    logic [31:0] fpc;
    logic        v;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic [31:0] ipc4;
  } mdl_t;

  function automatic mdl_t step(input mdl_t s, input logic rst, input logic stl,
                                input logic fl, input logic rv, input logic [31:0] rp);
    mdl_t n;
    n = s;
    if (rst) begin
      n = '{faulted: 1'b0, pc: 32'h0, fpc: 32'h0, v: 1'b0, inst: NOP, ipc: 32'h0, ipc4: 32'h0};
    end else if (!s.faulted) begin
      if (rv) begin
        n.v = 1'b0; n.inst = NOP;
        if (legal(rp)) n.pc = rp;
        else begin n.faulted = 1'b1; n.fpc = rp; end
      end else if (fl) begin
        n.v = 1'b0; n.inst = NOP;
      end else if (!stl) begin
        n.v = 1'b1; n.inst = fetch(s.pc); n.ipc = s.pc; n.ipc4 = s.pc + 32'd4;
        n.pc = s.pc + 32'd4;
        if (!legal(s.pc + 32'd4)) begin n.faulted = 1'b1; n.fpc = s.pc + 32'd4; end
      end
    end else begin
      if (rv && legal(rp)) begin
        n.faulted = 1'b0; n.pc = rp; n.v = 1'b0; n.inst = NOP;
      end else begin
        if (rv) n.fpc = rp;
        if (!stl) begin n.v = 1'b0; n.inst = NOP; end
      end
    end
    return n;
  endfunction

  mdl_t m;
  logic m_ok = 1'b0;

  always @(posedge clock) begin
    m <= step(m, reset, stall, flush, redirect_valid, redirect_pc);
    if (reset) m_ok <= 1'b1;
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clock) begin
    if (m_ok) begin
      cmp("m_imem_pc",   imem_pc,            m.pc);
      cmp("m_valid",     {31'b0, ifid_valid}, {31'b0, m.v});
      cmp("m_inst",      ifid_inst,          m.inst);
      cmp("m_ifid_pc",   ifid_pc,            m.ipc);
      cmp("m_pc_plus4",  ifid_pc_plus4,      m.ipc4);
      cmp("m_fault",     {31'b0, fault},     {31'b0, m.faulted});
      cmp("m_fault_pc",  fault_pc,           m.fpc);
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic exp_ifid(input string name, input logic v, input logic [31:0] pc,
                          input logic [31:0] inst);
    cmp({name, "_valid"}, {31'b0, ifid_valid}, {31'b0, v});
    cmp({name, "_inst"},  ifid_inst, inst);
    if (v) begin
      cmp({name, "_pc"},  ifid_pc, pc);
      cmp({name, "_pc4"}, ifid_pc_plus4, pc + 32'd4);
    end
  endtask

  initial begin
    logic [31:0] prog [0:4];
    prog[0] = 32'h0010_0113; prog[1] = 32'h0020_0193; prog[2] = 32'h0031_00B3;
    prog[3] = 32'h0031_0233; prog[4] = 32'h0031_02B3;
    for (int i = 0; i < 64; i++) begin
      logic [31:0] w;
      w = (i < 5) ? prog[i] : (32'h1000_0000 + 32'(i));
      mem[4*i]     = w[31:24];
      mem[4*i + 1] = w[23:16];
      mem[4*i + 2] = w[15:8];
      mem[4*i + 3] = w[7:0];
    end

    reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    tick(); tick();
    // Reset state
    exp_ifid("rst", 1'b0, 32'h0, NOP);
    cmp("rst_pc", imem_pc, 32'h0);
    cmp("rst_ifid_pc", ifid_pc, 32'h0);
    cmp("rst_fault", {31'b0, fault}, 32'h0);
    reset = 1'b0;

    // Sequential fetch
    tick(); exp_ifid("seq0", 1'b1, 32'h0, 32'h0010_0113);
    tick(); exp_ifid("seq1", 1'b1, 32'h4, 32'h0020_0193);
    cmp("seq_imem", imem_pc, 32'h8);

    // Stall 3 cycles at imem_pc=8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("stall_imem", imem_pc, 32'h8);
      exp_ifid("stall_hold", 1'b1, 32'h4, 32'h0020_0193);
    end
    stall = 1'b0;
    tick(); exp_ifid("post_stall", 1'b1, 32'h8, 32'h0031_00B3);

    // Redirect to 0x10
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick(); exp_ifid("redir_bub", 1'b0, 32'h0, NOP);
    cmp("redir_imem", imem_pc, 32'h10);
    redirect_valid = 1'b0;
    tick(); exp_ifid("redir_tgt", 1'b1, 32'h10, 32'h0031_02B3);

    // Misaligned redirect -> fault, PC frozen at 0x14
    redirect_valid = 1'b1; redirect_pc = 32'h0A;
    tick();
    cmp("mis_fault", {31'b0, fault}, 32'h1);
    cmp("mis_fpc", fault_pc, 32'h0A);
    cmp("mis_valid", {31'b0, ifid_valid}, 32'h0);
    cmp("mis_imem", imem_pc, 32'h14);
    redirect_valid = 1'b0;
    tick(); cmp("mis_frozen", imem_pc, 32'h14);
    // Illegal out-of-range redirect while faulted updates fault_pc
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick(); cmp("oor_fpc", fault_pc, 32'h100);
    cmp("oor_fault", {31'b0, fault}, 32'h1);
    // Recover with a legal redirect to 0
    redirect_pc = 32'h0;
    tick(); cmp("rec_fault", {31'b0, fault}, 32'h0);
    cmp("rec_imem", imem_pc, 32'h0);
    redirect_valid = 1'b0;
    tick(); exp_ifid("rec_first", 1'b1, 32'h0, 32'h0010_0113);

    // Redirect together with stall: redirect wins
    stall = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h8;
    tick(); exp_ifid("rs_bub", 1'b0, 32'h0, NOP);
    cmp("rs_imem", imem_pc, 32'h8);
    stall = 1'b0; redirect_valid = 1'b0;
    tick(); exp_ifid("rs_next", 1'b1, 32'h8, 32'h0031_00B3);

    // Flush with stall: bubble, PC held at 0xC
    flush = 1'b1; stall = 1'b1;
    tick(); exp_ifid("fs_bub", 1'b0, 32'h0, NOP);
    cmp("fs_imem", imem_pc, 32'hC);
    flush = 1'b0; stall = 1'b0;
    tick(); exp_ifid("fs_next", 1'b1, 32'hC, 32'h0031_0233);

    // Run off the end of memory
    redirect_valid = 1'b1; redirect_pc = 32'hF0;
    tick(); redirect_valid = 1'b0;
    tick(); tick(); tick();
    cmp("end_nofault", {31'b0, fault}, 32'h0);
    tick(); exp_ifid("end_last", 1'b1, 32'hFC, 32'h1000_003F);
    cmp("end_fault", {31'b0, fault}, 32'h1);
    cmp("end_fpc", fault_pc, 32'h100);
    tick(); exp_ifid("end_bub0", 1'b0, 32'h0, NOP);
    tick(); exp_ifid("end_bub1", 1'b0, 32'h0, NOP);

    // Reset while faulted and stalled
    stall = 1'b1; reset = 1'b1;
    tick();
    cmp("rf_pc", imem_pc, 32'h0);
    cmp("rf_fault", {31'b0, fault}, 32'h0);
    cmp("rf_fpc", fault_pc, 32'h0);
    cmp("rf_valid", {31'b0, ifid_valid}, 32'h0);
    reset = 1'b0; stall = 1'b0;
    tick(); exp_ifid("rf_first", 1'b1, 32'h0, 32'h0010_0113);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_fetch_stage
`default_nettype wire
